// File: rtl/sdr_ctrl_pkg.sv
// rtl/sdr_ctrl_pkg.sv - shared SDRAM controller states, pin encodings and field positions
package sdr_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_ACT      = 4'd1;
    localparam state_t ST_WAIT_RCD = 4'd2;
    localparam state_t ST_RW       = 4'd3;
    localparam state_t ST_WAIT_CL  = 4'd4;
    localparam state_t ST_PRE      = 4'd5;
    localparam state_t ST_WAIT_RP  = 4'd6;
    localparam state_t ST_DONE     = 4'd7;
    localparam state_t ST_REF      = 4'd8;
    localparam state_t ST_WAIT_RFC = 4'd9;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    localparam int BANK_MSB = 15;
    localparam int BANK_LSB = 14;
    localparam int ROW_MSB  = 13;
    localparam int ROW_LSB  = 8;
    localparam int COL_MSB  = 7;
    localparam int COL_LSB  = 0;
    localparam int PRE_ALL_BIT = 10;

    // current_cmd layout, shared with the command FIFO
    localparam int CMD_IS_WRITE_BIT = 32;
    localparam int CMD_ADDR_MSB     = 31;
    localparam int CMD_ADDR_LSB     = 16;
    localparam int CMD_WDATA_MSB    = 15;
    localparam int CMD_WDATA_LSB    = 0;

    typedef struct packed {
        logic        is_write;
        logic [15:0] addr;
        logic [15:0] wdata;
    } cmd_t;

endpackage

// File: rtl/sdr_refresh_timer.sv
// rtl/sdr_refresh_timer.sv - periodic refresh request timer with sticky pending flag
module sdr_refresh_timer
    import sdr_ctrl_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic pclk,
    input  logic preset,
    input  logic sys_init_done,
    input  logic ref_ack,
    output logic ref_pending
);

    localparam int CW = $clog2(REFRESH_INTERVAL);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

    logic [CW-1:0] count;
    logic          expire;

    assign expire = sys_init_done && (count == '0);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count       <= RELOAD;
            ref_pending <= 1'b0;
        end else begin
            if (!sys_init_done || expire) begin
                count <= RELOAD;
            end else begin
                count <= count - 1'b1;
            end
            // a second expiry while still pending folds into the same request
            if (expire) begin
                ref_pending <= 1'b1;
            end else if (ref_ack) begin
                ref_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdr_cmd_sequencer.sv
// rtl/sdr_cmd_sequencer.sv - ACT/RW/PRE command sequencing with refresh arbitration
module sdr_cmd_sequencer
    import sdr_ctrl_pkg::*;
#(
    parameter int T_RCD            = 2,
    parameter int T_RP             = 2,
    parameter int CAS_LAT          = 2,
    parameter int T_RFC            = 7,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        sys_init_done,
    input  logic        cmd_in_progress,
    input  logic [32:0] current_cmd,
    output logic        cmd_done,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        ref_busy,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic [15:0] sdr_dq_out,
    output logic        sdr_dq_oe,
    input  logic [15:0] sdr_dq_in
);

    // wait states last N cycles, so the counter loads N-1
    localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 2);
    localparam logic [7:0] CL_LOAD  = 8'(CAS_LAT - 1);
    localparam logic [7:0] RP_LOAD  = 8'(T_RP - 2);
    localparam logic [7:0] RFC_LOAD = 8'(T_RFC - 2);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] pin_cmd;
    cmd_t       cmd_q;
    cmd_t       cur_cmd;
    logic       ref_pending;
    logic       ref_ack;
    logic       rcd_done, cl_done, rp_done, rfc_done;

    assign cur_cmd = current_cmd;
    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = pin_cmd;
    assign ref_ack = (state == ST_IDLE) && sys_init_done && ref_pending;

    assign rcd_done = (state == ST_ACT && T_RCD == 1) || (state == ST_WAIT_RCD && cnt == 8'd0);
    assign cl_done  = (state == ST_RW && cmd_q.is_write) || (state == ST_WAIT_CL && cnt == 8'd0);
    assign rp_done  = (state == ST_PRE && T_RP == 1) || (state == ST_WAIT_RP && cnt == 8'd0);
    assign rfc_done = (state == ST_REF && T_RFC == 1) || (state == ST_WAIT_RFC && cnt == 8'd0);

    sdr_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_refresh_timer (
        .pclk          (pclk),
        .preset        (preset),
        .sys_init_done (sys_init_done),
        .ref_ack       (ref_ack),
        .ref_pending   (ref_pending)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            pin_cmd    <= CMD_NOP;
            cmd_q      <= '0;
            sdr_ba     <= 2'd0;
            sdr_addr   <= 13'd0;
            sdr_dq_oe  <= 1'b0;
            sdr_dq_out <= 16'd0;
            rd_data    <= 16'd0;
            cmd_done   <= 1'b0;
            rd_valid   <= 1'b0;
            ref_busy   <= 1'b0;
        end else begin
            pin_cmd    <= CMD_NOP;
            sdr_dq_oe  <= 1'b0;
            sdr_dq_out <= 16'd0;
            cmd_done   <= 1'b0;
            rd_valid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ref_ack) begin
                        state    <= ST_REF;
                        pin_cmd  <= CMD_REF;
                        ref_busy <= 1'b1;
                    end else if (sys_init_done && cmd_in_progress) begin
                        state    <= ST_ACT;
                        pin_cmd  <= CMD_ACT;
                        cmd_q    <= cur_cmd;
                        sdr_ba   <= cur_cmd.addr[BANK_MSB:BANK_LSB];
                        sdr_addr <= {7'b0, cur_cmd.addr[ROW_MSB:ROW_LSB]};
                    end
                end
                ST_ACT, ST_WAIT_RCD: begin
                    if (rcd_done) begin
                        state      <= ST_RW;
                        pin_cmd    <= cmd_q.is_write ? CMD_WRITE : CMD_READ;
                        sdr_addr   <= {5'b0, cmd_q.addr[COL_MSB:COL_LSB]};
                        sdr_dq_oe  <= cmd_q.is_write;
                        sdr_dq_out <= cmd_q.is_write ? cmd_q.wdata : 16'd0;
                    end else if (state == ST_ACT) begin
                        state <= ST_WAIT_RCD;
                        cnt   <= RCD_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RW, ST_WAIT_CL: begin
                    if (cl_done) begin
                        if (!cmd_q.is_write) begin
                            rd_data <= sdr_dq_in;
                        end
                        state    <= ST_PRE;
                        pin_cmd  <= CMD_PRE;
                        sdr_addr <= 13'(1) << PRE_ALL_BIT;
                    end else if (state == ST_RW) begin
                        state <= ST_WAIT_CL;
                        cnt   <= CL_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_PRE, ST_WAIT_RP: begin
                    if (rp_done) begin
                        state    <= ST_DONE;
                        cmd_done <= 1'b1;
                        rd_valid <= !cmd_q.is_write;
                    end else if (state == ST_PRE) begin
                        state <= ST_WAIT_RP;
                        cnt   <= RP_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_REF, ST_WAIT_RFC: begin
                    if (rfc_done) begin
                        state    <= ST_IDLE;
                        ref_busy <= 1'b0;
                    end else if (state == ST_REF) begin
                        state <= ST_WAIT_RFC;
                        cnt   <= RFC_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ref_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_cmd_sequencer.sv
// tb/tb_sdr_cmd_sequencer.sv - scoreboard bench for sdr_cmd_sequencer
module tb_sdr_cmd_sequencer;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        oe;
        logic [15:0] dq;
        logic        done;
        logic        rv;
        logic [15:0] rd;
    } ev_t;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        sys_init_done = 1'b0;
    logic        cmd_in_progress = 1'b0;
    logic [32:0] current_cmd = '0;
    logic [15:0] sdr_dq_in = '0;
    logic        cmd_done, rd_valid, ref_busy;
    logic [15:0] rd_data, sdr_dq_out;
    logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_dq_oe;
    logic [1:0]  sdr_ba;
    logic [12:0] sdr_addr;
    logic [3:0]  pins;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          rd_sample_cyc = -100;
    int          last_pre = -1;
    logic [15:0] rd_pad = 16'h0000;
    logic [32:0] fifo_q[$];
    ev_t         exp_q[$];
    ev_t         mon_e;

    assign pins = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    sdr_cmd_sequencer #(.REFRESH_INTERVAL(40)) dut (
        .pclk            (pclk),
        .preset          (preset),
        .sys_init_done   (sys_init_done),
        .cmd_in_progress (cmd_in_progress),
        .current_cmd     (current_cmd),
        .cmd_done        (cmd_done),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .ref_busy        (ref_busy),
        .sdr_cs_n        (sdr_cs_n),
        .sdr_ras_n       (sdr_ras_n),
        .sdr_cas_n       (sdr_cas_n),
        .sdr_we_n        (sdr_we_n),
        .sdr_ba          (sdr_ba),
        .sdr_addr        (sdr_addr),
        .sdr_dq_out      (sdr_dq_out),
        .sdr_dq_oe       (sdr_dq_oe),
        .sdr_dq_in       (sdr_dq_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] cmd, input logic [1:0] ba,
                           input logic [12:0] addr, input logic oe, input logic [15:0] dq,
                           input logic done, input logic rv, input logic [15:0] rd);
        ev_t e;
        e.cyc = c; e.cmd = cmd; e.ba = ba; e.addr = addr; e.oe = oe;
        e.dq = dq; e.done = done; e.rv = rv; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // write with defaults: ACT 1, WRITE 3, PRE 4, done 6 after grant cycle g
    task automatic expect_write(input int g, input logic [15:0] a, input logic [15:0] wd);
        push_ev(g + 1, C_ACT, a[15:14], {7'b0, a[13:8]}, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        push_ev(g + 3, C_WR,  a[15:14], {5'b0, a[7:0]},  1'b1, wd,    1'b0, 1'b0, 16'h0);
        push_ev(g + 4, C_PRE, 2'd0, 13'h0400, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        push_ev(g + 6, C_NOP, 2'd0, 13'h0000, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    endtask

    // read with defaults: READ 3, sample 5, PRE 6, done+valid 8
    task automatic expect_read(input int g, input logic [15:0] a, input logic [15:0] rd);
        push_ev(g + 1, C_ACT, a[15:14], {7'b0, a[13:8]}, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        push_ev(g + 3, C_RD,  a[15:14], {5'b0, a[7:0]},  1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        push_ev(g + 6, C_PRE, 2'd0, 13'h0400, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        push_ev(g + 8, C_NOP, 2'd0, 13'h0000, 1'b0, 16'h0, 1'b1, 1'b1, rd);
    endtask

    // command FIFO model: pops on cmd_done, cleared by reset
    always @(negedge pclk) begin
        #2;
        if (preset) begin
            fifo_q.delete();
        end else if (cmd_done && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        cmd_in_progress = (fifo_q.size() != 0);
        current_cmd = (fifo_q.size() != 0) ? fifo_q[0] : 33'h0;
    end

    always @(negedge pclk) begin
        sdr_dq_in = (cyc == rd_sample_cyc) ? rd_pad : 16'h0F0F;
    end

    // monitor: every non-idle pin cycle or completion pulse is matched against the scoreboard
    always @(negedge pclk) begin
        if (!preset && (pins != C_NOP || cmd_done || rd_valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {26'b0, pins, cmd_done, rd_valid}, {26'b0, C_NOP, 2'b00});
            end else begin
                mon_e = exp_q.pop_front();
                check("event_cycle", cyc, mon_e.cyc);
                check("pin_cmd", {28'b0, pins}, {28'b0, mon_e.cmd});
                if (mon_e.cmd == C_ACT || mon_e.cmd == C_RD || mon_e.cmd == C_WR) begin
                    check("sdr_ba", {30'b0, sdr_ba}, {30'b0, mon_e.ba});
                    check("sdr_addr", {19'b0, sdr_addr}, {19'b0, mon_e.addr});
                end
                if (mon_e.cmd == C_PRE) check("pre_a10", {31'b0, sdr_addr[10]}, 32'd1);
                if (mon_e.cmd == C_REF) check("ref_busy_at_ref", {31'b0, ref_busy}, 32'd1);
                check("dq_oe", {31'b0, sdr_dq_oe}, {31'b0, mon_e.oe});
                if (mon_e.oe) check("dq_out", {16'b0, sdr_dq_out}, {16'b0, mon_e.dq});
                check("cmd_done", {31'b0, cmd_done}, {31'b0, mon_e.done});
                check("rd_valid", {31'b0, rd_valid}, {31'b0, mon_e.rv});
                if (mon_e.rv) check("rd_data", {16'b0, rd_data}, {16'b0, mon_e.rd});
            end
            if (pins == C_ACT && last_pre >= 0) check("act_after_pre_gap", {31'b0, (cyc - last_pre) >= 3}, 32'd1);
            if (pins == C_PRE) last_pre = cyc;
        end
    end

    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1;
        sys_init_done = 1'b0;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        last_pre = -1;
        rd_sample_cyc = -100;
    endtask

    task automatic finish_test(input int n);
        repeat (n) @(negedge pclk);
        check("missing_events", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int busy;
        int active;

        repeat (3) @(negedge pclk);
        check("rst_pins", {28'b0, pins}, {28'b0, C_NOP});
        check("rst_ba", {30'b0, sdr_ba}, 32'd0);
        check("rst_addr", {19'b0, sdr_addr}, 32'd0);
        check("rst_dq_oe", {31'b0, sdr_dq_oe}, 32'd0);
        check("rst_dq_out", {16'b0, sdr_dq_out}, 32'd0);
        check("rst_rd_data", {16'b0, rd_data}, 32'd0);
        check("rst_cmd_done", {31'b0, cmd_done}, 32'd0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_ref_busy", {31'b0, ref_busy}, 32'd0);
        preset = 1'b0;

        // single write
        @(negedge pclk) sys_init_done = 1'b1;
        @(negedge pclk);
        fifo_q.push_back({1'b1, 16'h4123, 16'hBEEF});
        expect_write(cyc, 16'h4123, 16'hBEEF);
        finish_test(12);

        // single read, pad data only valid in the sample cycle
        do_reset();
        @(negedge pclk) sys_init_done = 1'b1;
        @(negedge pclk);
        fifo_q.push_back({1'b0, 16'h0005, 16'h0000});
        rd_pad = 16'hA5A5;
        rd_sample_cyc = cyc + 5;
        expect_read(cyc, 16'h0005, 16'hA5A5);
        finish_test(14);

        // refresh pending wins over a command arriving the same cycle
        do_reset();
        @(negedge pclk) sys_init_done = 1'b1;
        repeat (40) @(negedge pclk);
        fifo_q.push_back({1'b1, 16'h0110, 16'h7777});
        g = cyc;
        push_ev(g + 1, C_REF, 2'd0, 13'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        expect_write(g + 8, 16'h0110, 16'h7777);
        busy = 0;
        repeat (20) begin
            @(negedge pclk);
            if (ref_busy) busy++;
        end
        check("ref_busy_cycles", busy, 32'd7);
        finish_test(2);

        // init gating: a held command and a frozen timer while init is low
        do_reset();
        fifo_q.push_back({1'b1, 16'h2233, 16'h4455});
        active = 0;
        repeat (50) begin
            @(negedge pclk);
            if (pins != C_NOP) active++;
        end
        check("init_gate_active_pins", active, 32'd0);
        sys_init_done = 1'b1;
        expect_write(cyc, 16'h2233, 16'h4455);
        finish_test(10);

        // reset during WAIT_CL aborts the read
        do_reset();
        @(negedge pclk) sys_init_done = 1'b1;
        @(negedge pclk);
        fifo_q.push_back({1'b0, 16'h8007, 16'h0000});
        g = cyc;
        push_ev(g + 1, C_ACT, 2'd2, 13'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        push_ev(g + 3, C_RD,  2'd2, 13'h0007, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        rd_pad = 16'h1234;
        rd_sample_cyc = g + 5;
        repeat (4) @(negedge pclk);
        preset = 1'b1;
        #1;
        check("midrst_pins", {28'b0, pins}, {28'b0, C_NOP});
        check("midrst_dq_oe", {31'b0, sdr_dq_oe}, 32'd0);
        check("midrst_cmd_done", {31'b0, cmd_done}, 32'd0);
        check("midrst_rd_data", {16'b0, rd_data}, 32'd0);
        @(negedge pclk) preset = 1'b0;
        finish_test(10);
        fifo_q.push_back({1'b1, 16'h4321, 16'hCAFE});
        expect_write(cyc, 16'h4321, 16'hCAFE);
        finish_test(10);

        // three queued writes back to back
        do_reset();
        @(negedge pclk) sys_init_done = 1'b1;
        @(negedge pclk);
        fifo_q.push_back({1'b1, 16'h8102, 16'h1111});
        fifo_q.push_back({1'b1, 16'hC204, 16'h2222});
        fifo_q.push_back({1'b1, 16'h0306, 16'h3333});
        g = cyc;
        expect_write(g,      16'h8102, 16'h1111);
        expect_write(g + 7,  16'hC204, 16'h2222);
        expect_write(g + 14, 16'h0306, 16'h3333);
        finish_test(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
